test_seq_ctrl: RTL
==================

TEST_SEQ_CTRL -- requirements
Module: test_seq_ctrl

Interface
REQ-001 Parameter NUM_TESTS, default 8, number of test programs sequenced per run (1..255).
REQ-002 Parameter RST_CYCLES, default 4, cycles core_rst_n is held low before each test (>=1).
REQ-003 Parameter TIMEOUT, default 10000, watchdog limit in cycles per test (>=2).
REQ-004 Parameter TOHOST_ADDR, default 32'h0000_1000, data-memory address carrying test status.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port start  input  1  single-cycle request to begin a run.
REQ-008 Port dmem_we  input  1  core data-memory write strobe.
REQ-009 Port dmem_addr  input  32  core data-memory write address.
REQ-010 Port dmem_wdata  input  32  core data-memory write data.
REQ-011 Port core_rst_n  output  1  reset to core under test, active-low.
REQ-012 Port test_sel  output  8  index of the current test program.
REQ-013 Port busy  output  1  high in RST_CORE and RUN.
REQ-014 Port done  output  1  high in DONE.
REQ-015 Port pass_cnt, fail_cnt, timeout_cnt  output  16 each  result counters.
REQ-016 Port last_fail_code  output  31  dmem_wdata[31:1] of most recent failing status write.
REQ-017 Port all_pass  output  1  run verdict, valid when done=1.

Function
REQ-018 FSM states: IDLE, RST_CORE, RUN, DONE; exactly one active.
REQ-019 IDLE: core_rst_n=0; start=1 -> counters, test_sel, last_fail_code cleared, next state RST_CORE.
REQ-020 RST_CORE: core_rst_n=0 for exactly RST_CYCLES cycles, then RUN; watchdog cleared on entry to RUN.
REQ-021 RUN: core_rst_n=1; watchdog increments each cycle without a status write.
REQ-022 Status write = dmem_we=1 and dmem_addr==TOHOST_ADDR while in RUN; all other writes ignored.
REQ-023 dmem_wdata==1 -> pass_cnt+1; dmem_wdata[0]=1 and !=1 -> fail_cnt+1, last_fail_code<=dmem_wdata[31:1]; dmem_wdata[0]=0 -> ignored, test continues.
REQ-024 Watchdog reaching TIMEOUT-1 without result -> timeout_cnt+1 and fail_cnt+1 (test ends after exactly TIMEOUT RUN cycles).
REQ-025 Valid result and timeout in same cycle -> result wins, no timeout counted.
REQ-026 Test end: test_sel==NUM_TESTS-1 -> DONE; else test_sel+1 and next state RST_CORE (core_rst_n low the next cycle).
REQ-027 Counters saturate at 16'hFFFF, never wrap.
REQ-028 all_pass = done and (pass_cnt*100 > 99*NUM_TESTS), computed with >=24-bit arithmetic.
REQ-029 DONE: core_rst_n=0, outputs held; start=1 -> behaves as REQ-019 (new run).
REQ-030 start ignored while busy=1.
REQ-031 Status write in RST_CORE, IDLE or DONE has no effect.

Reset
REQ-032 rst_n=0 at a rising edge -> IDLE, core_rst_n=0, test_sel=0, busy=0, done=0, all counters 0, last_fail_code=0, watchdog 0.
REQ-033 Reset mid-run aborts the run immediately; no partial result recorded; start ignored while rst_n=0.

Verification
REQ-034 NUM_TESTS=4, each test writes 1 to TOHOST_ADDR after 50 cycles -> pass_cnt=4, fail_cnt=0, done=1, all_pass=1, test_sel=3.
REQ-035 Test 2 writes 32'h0000_0007 -> fail_cnt=1, last_fail_code=3, all_pass=0; writes of 32'h2 to TOHOST_ADDR and of 1 to TOHOST_ADDR+4 produce no count change.
REQ-036 TIMEOUT=100, no status write -> test ends after exactly 100 RUN cycles, timeout_cnt=1, fail_cnt=1, core_rst_n low next cycle for RST_CYCLES cycles.
REQ-037 Status write of 1 on final watchdog cycle -> pass_cnt+1, timeout_cnt unchanged.
REQ-038 rst_n=0 during RUN of test 1, then start -> all counters 0, test_sel=0, full run repeats; start pulses during busy ignored.

Source files
------------

// File: rtl/test_seq_ctrl.sv
// Sequences NUM_TESTS programs on a core under test: resets the core, watches the
// tohost status location for a verdict or a watchdog expiry, and tallies results.
module test_seq_ctrl #(
  parameter int          NUM_TESTS   = 8,
  parameter int          RST_CYCLES  = 4,
  parameter int          TIMEOUT     = 10000,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        core_rst_n,
  output logic [7:0]  test_sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic [15:0] timeout_cnt,
  output logic [30:0] last_fail_code,
  output logic        all_pass
);

  typedef enum logic [1:0] {IDLE, RST_CORE, RUN, DONE} state_t;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [7:0]      LAST_TEST = 8'(NUM_TESTS - 1);
  localparam logic [31:0]     PASS_BAR  = 32'(99 * NUM_TESTS);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        test_sel_q, test_sel_d;
  logic [15:0]       pass_q, pass_d;
  logic [15:0]       fail_q, fail_d;
  logic [15:0]       to_q, to_d;
  logic [30:0]       lfc_q, lfc_d;
  logic              status_valid;
  logic              test_end;
  logic [31:0]       pass_scaled;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      wd_q       <= '0;
      test_sel_q <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      to_q       <= '0;
      lfc_q      <= '0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      wd_q       <= wd_d;
      test_sel_q <= test_sel_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      to_q       <= to_d;
      lfc_q      <= lfc_d;
    end
  end

  // Only odd data at the tohost address is a verdict; even data is progress chatter.
  assign status_valid = dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];

  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    wd_d       = wd_q;
    test_sel_d = test_sel_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    to_d       = to_q;
    lfc_d      = lfc_q;
    test_end   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pass_d     = '0;
          fail_d     = '0;
          to_d       = '0;
          lfc_d      = '0;
          test_sel_d = '0;
          rc_d       = '0;
          state_d    = RST_CORE;
        end
      end
      RST_CORE: begin
        if (rc_q == RC_LAST) begin
          wd_d    = '0;
          state_d = RUN;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      RUN: begin
        // A verdict on the last watchdog cycle takes precedence over the timeout.
        if (status_valid) begin
          test_end = 1'b1;
          if (dmem_wdata == 32'd1) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
            lfc_d  = dmem_wdata[31:1];
          end
        end else if (wd_q == WD_LAST) begin
          test_end = 1'b1;
          to_d     = sat_inc(to_q);
          fail_d   = sat_inc(fail_q);
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
        if (test_end) begin
          if (test_sel_q == LAST_TEST) begin
            state_d = DONE;
          end else begin
            test_sel_d = test_sel_q + 8'd1;
            rc_d       = '0;
            state_d    = RST_CORE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pass_scaled    = 32'(pass_q) * 32'd100;
  assign core_rst_n     = (state_q == RUN);
  assign busy           = (state_q == RST_CORE) || (state_q == RUN);
  assign done           = (state_q == DONE);
  assign test_sel       = test_sel_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign timeout_cnt    = to_q;
  assign last_fail_code = lfc_q;
  assign all_pass       = (state_q == DONE) && (pass_scaled > PASS_BAR);

endmodule
